// File: rtl/seg_pkg.sv
// Shared definitions for the segment scan controller.
//   SEG_D0..SEG_D9 : 7-segment patterns, bit order {a,b,c,d,e,f,g,dp}
//   SEG_BLANK      : all segments off; also used for error and suppressed digits
//   scan_state_t   : scan FSM encoding (idle / blank slot head / drive)
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_D0    = 8'hFC;
  localparam logic [7:0] SEG_D1    = 8'h60;
  localparam logic [7:0] SEG_D2    = 8'hDA;
  localparam logic [7:0] SEG_D3    = 8'hF2;
  localparam logic [7:0] SEG_D4    = 8'h66;
  localparam logic [7:0] SEG_D5    = 8'hB6;
  localparam logic [7:0] SEG_D6    = 8'hBE;
  localparam logic [7:0] SEG_D7    = 8'hE0;
  localparam logic [7:0] SEG_D8    = 8'hFE;
  localparam logic [7:0] SEG_D9    = 8'hE6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-value input channel of the scan controller.
//   in_valid  : producer offers in_digits/in_lzs
//   in_ready  : consumer's shadow register is free
//   in_digits : BCD digits, [3:0] = digit 0 (least significant)
//   in_lzs    : leading-zero suppression flag, travels with in_digits
// Handshake: a transfer happens on every rising clk edge where in_valid and
// in_ready are both 1. in_digits/in_lzs only need to be stable in that cycle.
// in_ready does not depend on in_valid; the producer may raise in_valid at any
// time and must hold it (with stable data) until the transfer edge.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4*NUM_DIGITS-1:0] in_digits;
  logic                    in_lzs;

  modport master (output in_valid, output in_digits, output in_lzs, input in_ready);
  modport slave  (input in_valid, input in_digits, input in_lzs, output in_ready);
endinterface

// File: rtl/seg_decoder.sv
// BCD to 7-segment decoder (combinational).
//   bcd : 4-bit digit value
//   seg : pattern {a,b,c,d,e,f,g,dp}; values 10..15 give SEG_BLANK
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller.
// One 8-bit segment bus is shared by NUM_DIGITS positions. Each slot lasts
// SCAN_DIV clocks: BLANK_CYC dark cycles (anti-ghosting) then a DRIVE phase
// with one digit enabled. A new display value is taken into a shadow register
// via valid/ready and copied to the active register only when slot 0 is
// entered, so a frame never mixes old and new digits.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : scan enable, 0 = dark and counters cleared
//   in_bus     : display value channel (slave side)
//   seg        : segment bus {a,b,c,d,e,f,g,dp}, registered
//   dig_en     : one-hot digit enable (active-low at pins if DIG_ACTIVE_LOW)
//   frame_done : one-cycle pulse after the last DRIVE cycle of the last slot
//   dbg_state  : current scan FSM state
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 16,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  seg_scan_ctrl_if.slave        in_bus,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done,
  output scan_state_t           dbg_state
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLOT_W = $clog2(NUM_DIGITS);
  localparam int DIG_W  = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_DRIVE  = CNT_W'(BLANK_CYC);
  localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
  // A slot starts in BLANK unless there are no blank cycles at all.
  localparam scan_state_t           SLOT_ENTRY = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

  scan_state_t        state, state_n;
  logic [SLOT_W-1:0]  slot, slot_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               boundary;
  logic               fd_n;

  logic               shadow_full;
  logic [DIG_W-1:0]   shadow_digits;
  logic               shadow_lzs;
  logic [DIG_W-1:0]   act_digits, act_digits_n;
  logic               act_lzs, act_lzs_n;

  logic [3:0]            cur_bcd;
  logic [7:0]            dec_seg;
  logic                  suppress;
  logic [7:0]            seg_n;
  logic [NUM_DIGITS-1:0] dig_on;

  assign in_bus.in_ready = ~shadow_full;
  assign dbg_state       = state;

  // Next scan position. cnt runs 0..SCAN_DIV-1 across the whole slot; the
  // BLANK->DRIVE switch happens when it reaches BLANK_CYC.
  always_comb begin
    state_n  = state;
    slot_n   = slot;
    cnt_n    = cnt;
    boundary = 1'b0;
    fd_n     = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
      slot_n  = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n  = SLOT_ENTRY;
          slot_n   = '0;
          cnt_n    = '0;
          boundary = 1'b1;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = SLOT_ENTRY;
            if (slot == SLOT_LAST) begin
              slot_n   = '0;
              boundary = 1'b1;
              fd_n     = 1'b1;
            end else begin
              slot_n = slot + SLOT_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt_n == CNT_DRIVE) state_n = ST_DRIVE;
          end
        end
      endcase
    end
  end

  // Outputs are computed from the values the registers take at this edge, so
  // the first slot of a new frame already shows the newly applied value.
  always_comb begin
    act_digits_n = act_digits;
    act_lzs_n    = act_lzs;
    if (boundary && shadow_full) begin
      act_digits_n = shadow_digits;
      act_lzs_n    = shadow_lzs;
    end
  end

  assign cur_bcd = act_digits_n[{slot_n, 2'b00} +: 4];

  seg_decoder u_dec (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  // Digit k is suppressed when it and every digit above it is zero; digit 0
  // always shows.
  always_comb begin
    suppress = act_lzs_n && (slot_n != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(slot_n) && act_digits_n[4*k +: 4] != 4'd0) suppress = 1'b0;
    end
  end

  always_comb begin
    seg_n  = SEG_BLANK;
    dig_on = '0;
    if (state_n == ST_DRIVE) begin
      seg_n  = suppress ? SEG_BLANK : dec_seg;
      dig_on = NUM_DIGITS'(1) << slot_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      slot          <= '0;
      cnt           <= '0;
      seg           <= SEG_BLANK;
      dig_en        <= DIG_OFF;
      frame_done    <= 1'b0;
      shadow_full   <= 1'b0;
      shadow_digits <= '0;
      shadow_lzs    <= 1'b0;
      act_digits    <= '0;
      act_lzs       <= 1'b0;
    end else begin
      state      <= state_n;
      slot       <= slot_n;
      cnt        <= cnt_n;
      seg        <= seg_n;
      dig_en     <= dig_on ^ DIG_OFF;
      frame_done <= fd_n;
      act_digits <= act_digits_n;
      act_lzs    <= act_lzs_n;
      // A full shadow is never accepting, so apply and accept cannot collide.
      if (boundary && shadow_full) shadow_full <= 1'b0;
      if (in_bus.in_valid && !shadow_full) begin
        shadow_full   <= 1'b1;
        shadow_digits <= in_bus.in_digits;
        shadow_lzs    <= in_bus.in_lzs;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int ND = 3;
  localparam int SD = 8;
  localparam int BC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  logic [7:0]    seg;
  logic [ND-1:0] dig_en;
  logic          frame_done;
  scan_state_t   dbg_state;

  seg_scan_ctrl #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .BLANK_CYC      (BC),
    .DIG_ACTIVE_LOW (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_bus     (bus.slave),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  bit exp_rdy = 1'b1;
  bit offer_pending = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected in_ready bookkeeping after each edge: the boundary empties the
  // shadow, then a transfer taken on the same edge refills it.
  task automatic post_edge(input bit bnd);
    if (bnd) exp_rdy = 1'b1;
    if (offer_pending) begin
      exp_rdy       = 1'b0;
      offer_pending = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_digits = 12'($urandom);
      bus.in_lzs    = 1'($urandom);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] s, input logic [ND-1:0] d,
                         input logic fd);
    chk({tag, " seg"}, 16'(seg), 16'(s));
    chk({tag, " dig_en"}, 16'(dig_en), 16'(d));
    chk({tag, " frame_done"}, 16'(frame_done), 16'(fd));
    chk({tag, " in_ready"}, 16'(bus.in_ready), 16'(exp_rdy));
  endtask

  // One full slot: BC dark cycles then SD-BC drive cycles. offer_at >= 0
  // raises in_valid with od/ol after that cycle's checks.
  task automatic run_slot(input int slot, input logic [7:0] s, input bit fd0,
                          input int offer_at, input logic [11:0] od, input bit ol);
    string tag;
    for (int i = 0; i < SD; i++) begin
      tick();
      post_edge(slot == 0 && i == 0);
      tag = $sformatf("s%0d.c%0d", slot, i);
      chk_out(tag, (i < BC) ? 8'h00 : s, (i < BC) ? '0 : ND'(1 << slot),
              (slot == 0 && i == 0) ? fd0 : 1'b0);
      if (i == offer_at) begin
        bus.in_valid  = 1'b1;
        bus.in_digits = od;
        bus.in_lzs    = ol;
        offer_pending = 1'b1;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_digits = '0;
    bus.in_lzs    = 1'b0;

    // reset state
    #7;
    chk_out("reset", 8'h00, '0, 1'b0);
    chk("reset state", 16'(dbg_state), 16'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk_out("idle", 8'h00, '0, 1'b0);
    chk("idle state", 16'(dbg_state), 16'(ST_IDLE));

    // 1: first frame shows zeros; 2: offer 123 mid slot 1
    enable = 1'b1;
    run_slot(0, 8'hFC, 1'b0, -1, '0, 1'b0);
    run_slot(1, 8'hFC, 1'b0, 4, 12'h123, 1'b0);
    run_slot(2, 8'hFC, 1'b0, -1, '0, 1'b0);
    // 3: offer 007 with suppression
    run_slot(0, 8'hF2, 1'b1, -1, '0, 1'b0);
    run_slot(1, 8'hDA, 1'b0, 3, 12'h007, 1'b1);
    run_slot(2, 8'h60, 1'b0, -1, '0, 1'b0);
    // offer 000 with suppression
    run_slot(0, 8'hE0, 1'b1, -1, '0, 1'b0);
    run_slot(1, 8'h00, 1'b0, 5, 12'h000, 1'b1);
    run_slot(2, 8'h00, 1'b0, -1, '0, 1'b0);
    // 4: offer 0A5 (error digit), no suppression
    run_slot(0, 8'hFC, 1'b1, -1, '0, 1'b0);
    run_slot(1, 8'h00, 1'b0, 2, 12'h0A5, 1'b0);
    run_slot(2, 8'h00, 1'b0, -1, '0, 1'b0);
    // 5: free-running frames; value offered in the last cycle before the
    // boundary is taken on the boundary edge and waits one more frame
    run_slot(0, 8'hB6, 1'b1, -1, '0, 1'b0);
    run_slot(1, 8'h00, 1'b0, -1, '0, 1'b0);
    run_slot(2, 8'hFC, 1'b0, 7, 12'h321, 1'b0);
    run_slot(0, 8'hB6, 1'b1, -1, '0, 1'b0);
    run_slot(1, 8'h00, 1'b0, -1, '0, 1'b0);
    run_slot(2, 8'hFC, 1'b0, -1, '0, 1'b0);
    run_slot(0, 8'h60, 1'b1, -1, '0, 1'b0);
    run_slot(1, 8'hDA, 1'b0, -1, '0, 1'b0);
    run_slot(2, 8'hF2, 1'b0, -1, '0, 1'b0);

    // 6: disable mid slot 1 DRIVE
    run_slot(0, 8'h60, 1'b1, -1, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      post_edge(1'b0);
      chk_out($sformatf("part.c%0d", i), (i < BC) ? 8'h00 : 8'hDA,
              (i < BC) ? 3'b000 : 3'b010, 1'b0);
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      post_edge(1'b0);
      chk_out($sformatf("off.c%0d", i), 8'h00, 3'b000, 1'b0);
      chk("off state", 16'(dbg_state), 16'(ST_IDLE));
    end
    enable = 1'b1;
    run_slot(0, 8'h60, 1'b0, -1, '0, 1'b0);
    run_slot(1, 8'hDA, 1'b0, -1, '0, 1'b0);
    run_slot(2, 8'hF2, 1'b0, -1, '0, 1'b0);

    // async reset mid DRIVE with a pending shadow value (999)
    run_slot(0, 8'h60, 1'b1, 3, 12'h999, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      post_edge(1'b0);
      chk_out($sformatf("pre_rst.c%0d", i), (i < BC) ? 8'h00 : 8'hDA,
              (i < BC) ? 3'b000 : 3'b010, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_rdy = 1'b1;
    chk_out("async_rst", 8'h00, 3'b000, 1'b0);
    chk("async_rst state", 16'(dbg_state), 16'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_slot(0, 8'hFC, 1'b0, -1, '0, 1'b0);
    run_slot(1, 8'hFC, 1'b0, -1, '0, 1'b0);
    run_slot(2, 8'hFC, 1'b0, -1, '0, 1'b0);
    run_slot(0, 8'hFC, 1'b1, -1, '0, 1'b0);
    run_slot(1, 8'hFC, 1'b0, -1, '0, 1'b0);
    run_slot(2, 8'hFC, 1'b0, -1, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
